dt_bitpack: RTL and testbench

// - Reads an 8-bit distance map from the result RAM (same port shape as the DT res_* interface).
// - Thresholds each pixel and packs 16 pixels per word into the 16-bit binary-image word format.

---
 rtl/dt_bitpack.sv | 199 +++++++++++++++++++
 tb/tb_dt_bitpack.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dt_bitpack.sv
// Thresholds an 8-bit distance map read from the result RAM and packs 16 pixels per word, MSB first, into a sti-format RAM.
// Optional pixel population counter enabled by defining DT_BITPACK_POPCNT_EN.
module dt_bitpack #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int RAW   = 14,
    parameter int PAW   = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [7:0]     thr,
    output logic           busy,
    output logic           done,
    output logic           res_rd,
    output logic [RAW-1:0] res_addr,
    input  logic [7:0]     res_di,
    output logic           pk_wr,
    output logic [PAW-1:0] pk_addr,
    output logic [15:0]    pk_do,
    output logic [RAW:0]   pop_cnt
);

    localparam int WORDS = IMG_W * IMG_H / 16;
    localparam logic [PAW-1:0] LAST_WORD = PAW'(WORDS - 1);
    localparam int PW = RAW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [PAW-1:0] word_q, word_d, word_inc_s;
    logic [3:0]     k_q, k_d, k_inc_s;
    logic [15:0]    sr_q, sr_d;
    logic [7:0]     thr_q, thr_d;
    logic           capt_q, capt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           res_rd_q, res_rd_d;
    logic [RAW-1:0] res_addr_q, res_addr_d;
    logic           pk_wr_q, pk_wr_d;
    logic [PAW-1:0] pk_addr_q, pk_addr_d;
    logic [15:0]    pk_do_q, pk_do_d;

    // Next-state, capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        k_d        = k_q;
        thr_d      = thr_q;
        word_inc_s = word_q + PAW'(1);
        k_inc_s    = k_q + 4'd1;
        // Data returned by the RAM belongs to the read issued one cycle earlier
        capt_d     = res_rd_q;
        if (capt_q) begin
            sr_d = {sr_q[14:0], (res_di >= thr_q)};
        end else begin
            sr_d = sr_q;
        end
        res_rd_d   = 1'b0;
        res_addr_d = '0;
        pk_wr_d    = 1'b0;
        pk_addr_d  = '0;
        pk_do_d    = 16'h0000;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_READ;
                    thr_d      = thr;
                    word_d     = '0;
                    k_d        = 4'd0;
                    res_rd_d   = 1'b1;
                    res_addr_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (k_q == 4'd15) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d        = k_inc_s;
                    res_rd_d   = 1'b1;
                    res_addr_d = RAW'({word_q, k_inc_s});
                end
            end
            S_DRAIN: begin
                state_d   = S_WRITE;
                pk_wr_d   = 1'b1;
                pk_addr_d = word_q;
                pk_do_d   = sr_d;
            end
            S_WRITE: begin
                if (word_q == LAST_WORD) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_READ;
                    word_d     = word_inc_s;
                    k_d        = 4'd0;
                    res_rd_d   = 1'b1;
                    res_addr_d = RAW'({word_inc_s, 4'd0});
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            k_q        <= 4'd0;
            sr_q       <= 16'h0000;
            thr_q      <= 8'h00;
            capt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            pk_wr_q    <= 1'b0;
            pk_addr_q  <= '0;
            pk_do_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            k_q        <= k_d;
            sr_q       <= sr_d;
            thr_q      <= thr_d;
            capt_q     <= capt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            pk_wr_q    <= pk_wr_d;
            pk_addr_q  <= pk_addr_d;
            pk_do_q    <= pk_do_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_rd   = res_rd_q;
    assign res_addr = res_addr_q;
    assign pk_wr    = pk_wr_q;
    assign pk_addr  = pk_addr_q;
    assign pk_do    = pk_do_q;

`ifdef DT_BITPACK_POPCNT_EN
    function automatic logic [4:0] ones16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    logic [RAW:0] pop_q, pop_d;

    // Population count accumulates each word as it is written
    always_comb begin
        if ((state_q == S_IDLE) && start) begin
            pop_d = '0;
        end else if (pk_wr_q) begin
            pop_d = pop_q + PW'(ones16(pk_do_q));
        end else begin
            pop_d = pop_q;
        end
    end

    // Population count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end

    assign pop_cnt = pop_q;
`else
    assign pop_cnt = '0;
`endif

endmodule

// File: tb/tb_dt_bitpack.sv
// Directed bench for dt_bitpack: RAM models around the DUT, hand-derived expected words per map.
// Population-count expectations follow DT_BITPACK_POPCNT_EN.
module tb_dt_bitpack;

`ifdef DT_BITPACK_POPCNT_EN
    localparam bit POP_ON = 1'b1;
`else
    localparam bit POP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thr;
    logic        busy, done, res_rd, pk_wr;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic [9:0]  pk_addr;
    logic [15:0] pk_do;
    logic [14:0] pop_cnt;

    logic [7:0]  res_mem [0:16383];
    logic [15:0] pk_mem  [0:1023];
    logic        pk_clr = 1'b0;
    logic        mon_clr = 1'b0;

    int edge_cnt = 0;
    int base = 0;
    int wr_n = 0, done_n = 0, done_at = 0, ovl_n = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    dt_bitpack dut (
        .clk(clk), .reset(reset), .start(start), .thr(thr),
        .busy(busy), .done(done), .res_rd(res_rd), .res_addr(res_addr),
        .res_di(res_di), .pk_wr(pk_wr), .pk_addr(pk_addr), .pk_do(pk_do),
        .pop_cnt(pop_cnt)
    );

    // Result RAM (read latency 1) and packed RAM models
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (res_rd) res_di <= res_mem[res_addr];
        if (pk_clr) begin
            for (int i = 0; i < 1024; i++) pk_mem[i] <= 16'hDEAD;
        end else if (pk_wr) begin
            pk_mem[pk_addr] <= pk_do;
        end
    end

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_n = 0; done_n = 0; done_at = 0; ovl_n = 0;
        end else begin
            if (pk_wr) wr_n = wr_n + 1;
            if (pk_wr && res_rd) ovl_n = ovl_n + 1;
            if (done) begin
                done_n = done_n + 1;
                done_at = edge_cnt - base;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int mode, input int w);
        case (mode)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return (w == 5) ? 16'h8000 : 16'h0000;
            3: return (w == 5) ? 16'h0001 : (w[3] ? 16'hFFFF : 16'h0000);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic prep();
        @(posedge clk); #1;
        mon_clr = 1'b1; pk_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0; pk_clr = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] t);
        @(negedge clk);
        base = edge_cnt;
        start = 1'b1; thr = t;
        @(negedge clk);
        start = 1'b0; thr = ~t;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_n == 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_no_timeout"}, {31'd0, (done_n == 0)}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic check_run(input string tag, input int mode, input int pop_exp);
        int bad, first;
        bad = 0; first = -1;
        for (int w = 0; w < 1024; w++) begin
            if (pk_mem[w] !== exp_word(mode, w)) begin
                bad++;
                if (first < 0) first = w;
            end
        end
        chk({tag, "_bad_words"}, bad, 32'd0);
        if (bad != 0) $display("  first bad word %0d = %h", first, pk_mem[first]);
        chk({tag, "_pk_wr_count"}, wr_n, 32'd1024);
        chk({tag, "_done_count"}, done_n, 32'd1);
        chk({tag, "_done_cycle"}, done_at, 32'd18433);
        chk({tag, "_rd_wr_overlap"}, ovl_n, 32'd0);
        chk({tag, "_pop_cnt"}, {17'd0, pop_cnt}, POP_ON ? pop_exp : 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_outs"}, {busy, done, res_rd, pk_wr, 28'd0}, 32'd0);
        chk({tag, "_res_addr"}, {18'd0, res_addr}, 32'd0);
        chk({tag, "_pk_addr_do"}, {6'd0, pk_addr, pk_do}, 32'd0);
        chk({tag, "_pop_cnt"}, {17'd0, pop_cnt}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; thr = 8'h00;
        for (int a = 0; a < 16384; a++) res_mem[a] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // Aborted run on an all-zero map: reset lands mid-word 500
        prep();
        start_run(8'd1);
        while ((edge_cnt - base) < 9005) @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        chk("abort_words_written", wr_n, 32'd500);
        chk("abort_word499", {16'd0, pk_mem[499]}, 32'h0000);
        chk("abort_word500_untouched", {16'd0, pk_mem[500]}, 32'hDEAD);
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("held_reset");
        reset = 1'b1;
        @(negedge clk);

        // Full all-zero run after reset, thr=1
        prep();
        start_run(8'd1);
        wait_done("zero");
        check_run("zero", 0, 0);

        // All-3 map with thr=0: every bit set
        for (int a = 0; a < 16384; a++) res_mem[a] = 8'd3;
        prep();
        start_run(8'd0);
        wait_done("thr0");
        check_run("thr0", 1, 16384);

        // Single pixel 0 of word 5; a second start with thr=0 at cycle ~100 must be ignored
        for (int a = 0; a < 16384; a++) res_mem[a] = 8'h00;
        res_mem[80] = 8'd7;
        prep();
        start_run(8'd4);
        repeat (98) @(negedge clk);
        start = 1'b1; thr = 8'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("pix0");
        check_run("pix0", 2, 1);
        chk("pix0_word5", {16'd0, pk_mem[5]}, 32'h8000);

        // Ramp map, thr=128, plus pixel 15 of word 5 forced high
        for (int a = 0; a < 16384; a++) res_mem[a] = a[7:0];
        res_mem[95] = 8'd200;
        prep();
        start_run(8'd128);
        wait_done("ramp");
        check_run("ramp", 3, 8193);
        chk("ramp_word5", {16'd0, pk_mem[5]}, 32'h0001);
        chk("ramp_word7", {16'd0, pk_mem[7]}, 32'h0000);
        chk("ramp_word8", {16'd0, pk_mem[8]}, 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
